// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode constants, legality check and requester-id type shared by
//          the ALU and its two-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SLT = 4'b0100;
    localparam logic [3:0] ALUOP_XOR = 4'b0101;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SLT, ALUOP_XOR,
            ALUOP_SUB, ALUOP_SRL, ALUOP_SLL, ALUOP_SRA: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu
// Brief  : Combinational 32-bit ALU; unknown opcodes yield zero and a flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [3:0]  i_alu_op,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_illegal
);

    logic [31:0] w_result;
    logic [4:0]  w_shamt;

    assign w_shamt = i_op2[4:0];

    always_comb begin
        w_result = '0;
        case (i_alu_op)
            ALUOP_AND: w_result = i_op1 & i_op2;
            ALUOP_OR:  w_result = i_op1 | i_op2;
            ALUOP_ADD: w_result = i_op1 + i_op2;
            ALUOP_SUB: w_result = i_op1 - i_op2;
            ALUOP_SLT: w_result = {31'd0, ($signed(i_op1) < $signed(i_op2))};
            ALUOP_XOR: w_result = i_op1 ^ i_op2;
            ALUOP_SRL: w_result = i_op1 >> w_shamt;
            ALUOP_SLL: w_result = i_op1 << w_shamt;
            ALUOP_SRA: w_result = $unsigned($signed(i_op1) >>> w_shamt);
            default:   w_result = '0;
        endcase
    end

    assign o_result  = w_result;
    assign o_zero    = (w_result == 32'd0);
    assign o_illegal = !is_legal_op(i_alu_op);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Shares one ALU between two valid/ready requesters (round-robin or
//          fixed priority) with a one-deep registered response slot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FAIR_RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic [3:0]  req0_alu_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic [3:0]  req1_alu_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t r_state;
    slot_state_t w_state_nxt;

    req_id_t     r_ptr;
    req_id_t     w_grant;
    req_id_t     r_id;
    logic        w_can_accept;
    logic        w_hs;

    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [3:0]  w_alu_op;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_alu_illegal;

    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;

    assign w_can_accept = (r_state == S_EMPTY) || rsp_ready;

    // Grant depends on both valids; readies may therefore see the other port's valid.
    always_comb begin
        w_grant = REQ0;
        if (req0_valid && req1_valid) begin
            w_grant = FAIR_RR ? r_ptr : REQ0;
        end else if (req1_valid) begin
            w_grant = REQ1;
        end
    end

    assign req0_ready = w_can_accept && (w_grant == REQ0);
    assign req1_ready = w_can_accept && (w_grant == REQ1);
    assign w_hs       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign w_op1    = (w_grant == REQ1) ? req1_op1    : req0_op1;
    assign w_op2    = (w_grant == REQ1) ? req1_op2    : req0_op2;
    assign w_alu_op = (w_grant == REQ1) ? req1_alu_op : req0_alu_op;

    alu u_alu (
        .i_op1     (w_op1),
        .i_op2     (w_op2),
        .i_alu_op  (w_alu_op),
        .o_result  (w_alu_result),
        .o_zero    (w_alu_zero),
        .o_illegal (w_alu_illegal)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            w_state_nxt = S_FULL;
        end else if ((r_state == S_FULL) && rsp_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_ptr     <= REQ0;
            r_id      <= REQ0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_ptr     <= ~w_grant;
                r_id      <= w_grant;
                r_result  <= w_alu_result;
                r_zero    <= w_alu_zero;
                r_illegal <= w_alu_illegal;
            end
        end
    end

    assign rsp_valid   = (r_state == S_FULL);
    assign rsp_id      = r_id;
    assign rsp_result  = r_result;
    assign rsp_zero    = r_zero;
    assign rsp_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Self-checking bench driving a round-robin and a fixed-priority
//          arbiter with shared stimulus against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]  req0_alu_op, req1_alu_op;

    logic        rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_zero, rr_rsp_illegal;
    logic [31:0] rr_rsp_result;
    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zero, fp_rsp_illegal;
    logic [31:0] fp_rsp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR_RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
        .rsp_result(rr_rsp_result), .rsp_zero(rr_rsp_zero), .rsp_illegal(rr_rsp_illegal)
    );

    alu_arbiter #(.FAIR_RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .rsp_illegal(fp_rsp_illegal)
    );

    // Index 0 = round-robin instance, index 1 = fixed-priority instance.
    logic [1:0]  obs_rdy [2];
    logic [34:0] obs_rsp [2];
    assign obs_rdy[0] = {rr_req1_ready, rr_req0_ready};
    assign obs_rdy[1] = {fp_req1_ready, fp_req0_ready};
    assign obs_rsp[0] = rr_rsp_valid ? {1'b1, rr_rsp_id, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result} : 35'd0;
    assign obs_rsp[1] = fp_rsp_valid ? {1'b1, fp_rsp_id, fp_rsp_illegal, fp_rsp_zero, fp_rsp_result} : 35'd0;

    int          n_cmp  = 0;
    int          n_fail = 0;

    logic [1:0]  m_full, m_ptr, m_id, m_zero, m_ill;
    logic [31:0] m_res [2];
    logic [1:0]  exp_hs [2];
    logic [1:0]  obs_hs [2];

    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0101: r = a ^ b;
            4'b0100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: r = a >> sh;
            4'b1001: r = a << sh;
            4'b1010: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic logic [34:0] exp_rsp(input int k);
        if (!m_full[k]) return 35'd0;
        return {1'b1, m_id[k], m_ill[k], m_zero[k], m_res[k]};
    endfunction

    task automatic model_reset();
        m_full = '0; m_ptr = '0; m_id = '0; m_zero = '0; m_ill = '0;
        m_res[0] = '0; m_res[1] = '0;
    endtask

    // Advances one clock: predicts handshakes, samples DUT readies, updates the model.
    task automatic tick();
        logic win [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            logic can;
            can = !m_full[k] || rsp_ready;
            if (req0_valid && req1_valid) win[k] = (k == 0) ? m_ptr[k] : 1'b0;
            else                          win[k] = req1_valid;
            exp_hs[k] = 2'b00;
            if (can && (req0_valid || req1_valid)) exp_hs[k][win[k]] = 1'b1;
            obs_hs[k] = obs_rdy[k] & {req1_valid, req0_valid};
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (exp_hs[k] != 2'b00) begin
                logic [32:0] r;
                r = win[k] ? ref_alu(req1_alu_op, req1_op1, req1_op2)
                           : ref_alu(req0_alu_op, req0_op1, req0_op2);
                m_full[k] = 1'b1;
                m_id[k]   = win[k];
                m_ptr[k]  = ~win[k];
                m_ill[k]  = r[32];
                m_res[k]  = r[31:0];
                m_zero[k] = (r[31:0] == 32'd0);
            end else if (m_full[k] && rsp_ready) begin
                m_full[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic rand_ops();
        req0_op1 = $urandom; req0_op2 = $urandom; req0_alu_op = 4'($urandom_range(0, 15));
        req1_op1 = $urandom; req1_op2 = $urandom; req1_alu_op = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_op1 = 0; req0_op2 = 0; req0_alu_op = 0;
        req1_op1 = 0; req1_op2 = 0; req1_alu_op = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rr_rsp_valid, rr_rsp_id, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result} !== 35'd0) begin
            n_fail++; $display("FAIL reset_rr: got %h want 0", {rr_rsp_valid, rr_rsp_id, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result});
        end
        n_cmp++;
        if ({fp_rsp_valid, fp_rsp_id, fp_rsp_illegal, fp_rsp_zero, fp_rsp_result} !== 35'd0) begin
            n_fail++; $display("FAIL reset_fp: got %h want 0", {fp_rsp_valid, fp_rsp_id, fp_rsp_illegal, fp_rsp_zero, fp_rsp_result});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        req0_valid = 1; req1_valid = 0; rsp_ready = 1;
        req0_op1 = 32'd5; req0_op2 = 32'd7; req0_alu_op = 4'b0010;
        tick();
        req0_valid = 0;
        n_cmp++;
        if ({rr_rsp_valid, rr_rsp_id, rr_rsp_zero, rr_rsp_result} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin
            n_fail++; $display("FAIL add_5_7: got v=%b id=%b z=%b r=%0d want v=1 id=0 z=0 r=12",
                               rr_rsp_valid, rr_rsp_id, rr_rsp_zero, rr_rsp_result);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_hs[k] !== exp_hs[k] || obs_rsp[k] !== exp_rsp(k)) begin
                n_fail++; $display("FAIL add_model[%0d]: got hs=%b rsp=%h want hs=%b rsp=%h", k, obs_hs[k], obs_rsp[k], exp_hs[k], exp_rsp(k));
            end
        end
    endtask

    task automatic test_both_valid();
        logic expect_id;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        expect_id = m_ptr[0];
        for (int c = 0; c < 8; c++) begin
            rand_ops();
            tick();
            n_cmp++;
            if (!rr_rsp_valid || rr_rsp_id !== expect_id) begin
                n_fail++; $display("FAIL rr_alternate c%0d: got v=%b id=%b want v=1 id=%b", c, rr_rsp_valid, rr_rsp_id, expect_id);
            end
            expect_id = ~expect_id;
            n_cmp++;
            if (!fp_rsp_valid || fp_rsp_id !== 1'b0 || obs_hs[1] !== 2'b01) begin
                n_fail++; $display("FAIL fp_priority c%0d: got v=%b id=%b hs=%b want v=1 id=0 hs=01", c, fp_rsp_valid, fp_rsp_id, obs_hs[1]);
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_hs[k] !== exp_hs[k] || obs_rsp[k] !== exp_rsp(k)) begin
                    n_fail++; $display("FAIL both_model[%0d] c%0d: got hs=%b rsp=%h want hs=%b rsp=%h", k, c, obs_hs[k], obs_rsp[k], exp_hs[k], exp_rsp(k));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        req0_valid = 1; req1_valid = 0; rsp_ready = 1;
        rand_ops();
        tick();
        req1_valid = 1; rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_hs[k] !== 2'b00 || obs_rdy[k] !== 2'b00 || obs_rsp[k] !== exp_rsp(k)) begin
                    n_fail++; $display("FAIL hold[%0d] c%0d: got rdy=%b rsp=%h want rdy=00 rsp=%h", k, c, obs_rdy[k], obs_rsp[k], exp_rsp(k));
                end
            end
        end
        rsp_ready = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_hs[k] === 2'b00 || obs_hs[k] !== exp_hs[k] || obs_rsp[k] !== exp_rsp(k)) begin
                n_fail++; $display("FAIL no_bubble[%0d]: got hs=%b rsp=%h want hs=%b rsp=%h", k, obs_hs[k], obs_rsp[k], exp_hs[k], exp_rsp(k));
            end
        end
    endtask

    task automatic test_directed_ops();
        logic [3:0]  ops [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] res [4];
        logic        zero [4];
        ops[0] = 4'b0110; a[0] = 32'd3;          b[0] = 32'd3; res[0] = 32'd0;          zero[0] = 1;
        ops[1] = 4'b0100; a[1] = 32'hFFFF_FFFF;  b[1] = 32'd1; res[1] = 32'd1;          zero[1] = 0;
        ops[2] = 4'b1010; a[2] = 32'h8000_0000;  b[2] = 32'd4; res[2] = 32'hF800_0000; zero[2] = 0;
        ops[3] = 4'b0010; a[3] = 32'hFFFF_FFFF;  b[3] = 32'd1; res[3] = 32'd0;          zero[3] = 1;
        rsp_ready = 1;
        for (int port = 0; port < 2; port++) begin
            for (int i = 0; i < 4; i++) begin
                req0_valid = (port == 0); req1_valid = (port == 1);
                req0_op1 = a[i]; req0_op2 = b[i]; req0_alu_op = ops[i];
                req1_op1 = a[i]; req1_op2 = b[i]; req1_alu_op = ops[i];
                tick();
                n_cmp++;
                if ({rr_rsp_valid, rr_rsp_id, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result} !==
                    {1'b1, 1'(port), 1'b0, zero[i], res[i]}) begin
                    n_fail++; $display("FAIL op%0d_port%0d: got v=%b id=%b ill=%b z=%b r=%h want v=1 id=%0d ill=0 z=%b r=%h",
                                       i, port, rr_rsp_valid, rr_rsp_id, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result, port, zero[i], res[i]);
                end
            end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_illegal();
        req0_valid = 1; req1_valid = 0; rsp_ready = 1;
        req0_op1 = 32'h1234_5678; req0_op2 = 32'h1111_1111; req0_alu_op = 4'b1111;
        tick();
        req0_valid = 0;
        n_cmp++;
        if (obs_hs[0] !== 2'b01 || {rr_rsp_valid, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
            n_fail++; $display("FAIL illegal_op: got hs=%b v=%b ill=%b z=%b r=%h want hs=01 v=1 ill=1 z=1 r=0",
                               obs_hs[0], rr_rsp_valid, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            rand_ops();
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_hs[k] !== exp_hs[k] || obs_rsp[k] !== exp_rsp(k)) begin
                    n_fail++;
                    if (bad < 10) $display("FAIL random[%0d] c%0d: got hs=%b rsp=%h want hs=%b rsp=%h", k, c, obs_hs[k], obs_rsp[k], exp_hs[k], exp_rsp(k));
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        req0_valid = 1; req1_valid = 0; rsp_ready = 1;
        rand_ops();
        tick();
        req1_valid = 1; rsp_ready = 0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rr_rsp_valid, rr_rsp_id, rr_rsp_illegal, rr_rsp_zero, rr_rsp_result,
             fp_rsp_valid, fp_rsp_id, fp_rsp_illegal, fp_rsp_zero, fp_rsp_result} !== 70'd0) begin
            n_fail++; $display("FAIL async_reset: got rr_v=%b rr_r=%h fp_v=%b fp_r=%h want all 0",
                               rr_rsp_valid, rr_rsp_result, fp_rsp_valid, fp_rsp_result);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_hs[k] !== 2'b01 || obs_rsp[k] !== exp_rsp(k)) begin
                n_fail++; $display("FAIL post_reset_grant[%0d]: got hs=%b rsp=%h want hs=01 rsp=%h", k, obs_hs[k], obs_rsp[k], exp_rsp(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_both_valid();
        test_backpressure();
        test_directed_ops();
        test_illegal();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
